// File: rtl/apb_cfg_loader.sv
// APB write-only master that streams a packed configuration vector into the
// register bank of the APB configuration slave, then issues the commit write
// at address NBR_REGS and waits (bounded by TIMEOUT_CYC) for it to complete.
module apb_cfg_loader #(
    parameter int unsigned NBR_REGS    = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                        clk_apb,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [32*NBR_REGS-1:0]      cfg_regs_p,
    output logic                        busy,
    output logic                        done,
    output logic                        err_timeout,
    output logic [$clog2(NBR_REGS):0]   paddr,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [31:0]                 pwdata,
    input  logic                        pready
);

    localparam int unsigned AW = $clog2(NBR_REGS) + 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_d;
    logic [CW-1:0]   tmo_q;
    logic [31:0]     wdata_d;

    // paddr always mirrors the transfer index, which is itself a register
    assign paddr = idx_q;

    // Next index and its write word; the commit slot (idx = NBR_REGS) matches
    // no word and therefore yields 0
    always_comb begin
        idx_d   = idx_q + AW'(1);
        wdata_d = '0;
        for (int unsigned i = 0; i < NBR_REGS; i++) begin
            if (idx_d == AW'(i)) begin
                wdata_d = cfg_regs_p[32*i +: 32];
            end
        end
    end

    // Transfer sequencer with registered APB and status outputs
    always_ff @(posedge clk_apb or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= SETUP;
                        idx_q       <= '0;
                        pwdata      <= cfg_regs_p[31:0];
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        psel        <= 1'b1;
                        penable     <= 1'b0;
                        pwrite      <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    penable <= 1'b1;
                    tmo_q   <= '0;
                end
                ACCESS: begin
                    // pready takes priority over the terminal wait count
                    if (pready) begin
                        if (idx_q == AW'(NBR_REGS)) begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            psel    <= 1'b0;
                            penable <= 1'b0;
                            pwrite  <= 1'b0;
                        end else begin
                            state_q <= SETUP;
                            idx_q   <= idx_d;
                            pwdata  <= wdata_d;
                            penable <= 1'b0;
                        end
                    end else if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
                        state_q     <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_loader.sv
// Self-checking bench for apb_cfg_loader (NBR_REGS=4, TIMEOUT_CYC=8): a table of
// directed sequences, a reset-abort sequence and randomized sequences, all
// checked against an arithmetic model of transfer order and completion time.
module tb_apb_cfg_loader;

    localparam int N = 4;
    localparam int T = 8;

    logic            clk_apb = 1'b0;
    logic            rst_n;
    logic            start;
    logic            pready;
    logic [32*N-1:0] cfg;
    logic            busy, done, err_timeout, psel, penable, pwrite;
    logic [2:0]      paddr;
    logic [31:0]     pwdata;

    int checks = 0;
    int errors = 0;

    // Slave-side state: per-transfer wait counts and expected transfer list
    logic [4:0][7:0] waits;
    int              xfer, acc_cnt, ncomp;
    int              exp_addr[$];
    logic [31:0]     exp_data[$];

    typedef struct packed {
        logic [4:0][7:0] w;
        int              exp_done;
        bit              exp_err;
        bit              spam;
        bit              chain;
    } vec_t;

    apb_cfg_loader #(.NBR_REGS(N), .TIMEOUT_CYC(T)) dut (
        .clk_apb     (clk_apb),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_regs_p  (cfg),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready)
    );

    always #5 clk_apb = ~clk_apb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0][7:0] mkw(input int a, input int b, input int c,
                                            input int d, input int e);
        logic [4:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d); r[4] = 8'(e);
        return r;
    endfunction

    // Completion model: a transfer with w wait cycles occupies 2+w cycles;
    // a transfer needing T or more waits aborts T cycles after its ACCESS begins.
    function automatic void model(input logic [4:0][7:0] w, output int dc,
                                  output bit er, output int nx);
        int t;
        t  = 1;
        dc = 0;
        er = 1'b0;
        nx = N + 1;
        for (int i = 0; i < N + 1; i++) begin
            if (int'(w[i]) >= T) begin
                dc = t + 1 + T;
                er = 1'b1;
                nx = i;
                return;
            end
            t += 2 + int'(w[i]);
        end
        dc = t;
    endfunction

    // Responding slave: checks every ACCESS cycle against the expected
    // transfer and raises pready after the scheduled number of wait cycles
    always @(negedge clk_apb) begin
        if (psel && penable) begin
            chk("xfer_expected", 64'(exp_addr.size() != 0), 64'd1);
            if (exp_addr.size() != 0) begin
                chk("paddr", 64'(paddr), 64'(exp_addr[0]));
                chk("pwdata", 64'(pwdata), 64'(exp_data[0]));
                chk("pwrite", 64'(pwrite), 64'd1);
                if (xfer <= N && acc_cnt == int'(waits[xfer])) begin
                    pready = 1'b1;
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                    xfer++;
                    ncomp++;
                    acc_cnt = 0;
                end else begin
                    pready = 1'b0;
                    acc_cnt++;
                end
            end
        end else begin
            pready = 1'b0;
        end
    end

    task automatic setup_seq(input logic [32*N-1:0] words, input logic [4:0][7:0] w);
        cfg   = words;
        waits = w;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(words[32*i +: 32]);
        end
        exp_addr.push_back(N);
        exp_data.push_back(32'h0);
        xfer    = 0;
        acc_cnt = 0;
        ncomp   = 0;
    endtask

    task automatic run_seq(input logic [32*N-1:0] words, input logic [4:0][7:0] w,
                           input bit pre, input bit chain, input bit spam,
                           input bit use_tbl, input int tdone, input bit terr);
        int dc, nx, c, edone;
        bit er, eerr;
        model(w, dc, er, nx);
        edone = use_tbl ? tdone : dc;
        eerr  = use_tbl ? terr : er;
        setup_seq(words, w);
        if (!pre) begin
            @(negedge clk_apb);
            start = 1'b1;
        end
        @(posedge clk_apb);
        @(negedge clk_apb);
        start = 1'b0;
        c = 1;
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_psel", 64'(psel), 64'd1);
        chk("c1_penable", 64'(penable), 64'd0);
        chk("c1_paddr", 64'(paddr), 64'd0);
        chk("c1_pwdata", 64'(pwdata), 64'(words[31:0]));
        chk("c1_err", 64'(err_timeout), 64'd0);
        while (!done && c < edone + 20) begin
            start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk_apb);
            c++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_cycle", 64'(c), 64'(edone));
        chk("done_err", 64'(err_timeout), 64'(eerr));
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_psel", 64'(psel), 64'd0);
        chk("done_penable", 64'(penable), 64'd0);
        chk("xfer_count", 64'(ncomp), 64'(nx));
        if (chain) begin
            start = 1'b1;
        end else begin
            start = 1'b0;
            repeat (3) begin
                @(negedge clk_apb);
                chk("idle_done", 64'(done), 64'd0);
                chk("idle_busy", 64'(busy), 64'd0);
                chk("idle_err", 64'(err_timeout), 64'(eerr));
            end
        end
    endtask

    initial begin
        automatic vec_t            tbl[8];
        automatic logic [32*N-1:0] tp_words;
        automatic logic [32*N-1:0] rw;
        automatic logic [4:0][7:0] w;
        automatic bit              prev_chain;
        automatic int              r;

        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic vec_t            tbl[8];
        automatic logic [32*N-1:0] tp_words;
        automatic logic [32*N-1:0] rw;
        automatic logic [4:0][7:0] w;
        automatic bit              prev_chain;
        automatic int              r;

        tp_words = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        // w[i] = wait cycles for transfer i (index 4 is the commit); 99 = stuck
        tbl[0] = '{w: mkw(0, 0, 0, 0, 0),  exp_done: 11, exp_err: 0, spam: 0, chain: 0};
        tbl[1] = '{w: mkw(0, 0, 0, 0, 7),  exp_done: 18, exp_err: 0, spam: 0, chain: 0};
        tbl[2] = '{w: mkw(0, 0, 0, 0, 99), exp_done: 18, exp_err: 1, spam: 0, chain: 0};
        tbl[3] = '{w: mkw(7, 7, 7, 7, 7),  exp_done: 46, exp_err: 0, spam: 0, chain: 0};
        tbl[4] = '{w: mkw(1, 0, 3, 0, 0),  exp_done: 15, exp_err: 0, spam: 1, chain: 0};
        tbl[5] = '{w: mkw(0, 99, 0, 0, 0), exp_done: 12, exp_err: 1, spam: 0, chain: 1};
        tbl[6] = '{w: mkw(0, 0, 0, 0, 0),  exp_done: 11, exp_err: 0, spam: 0, chain: 0};
        tbl[7] = '{w: mkw(0, 0, 0, 0, 6),  exp_done: 17, exp_err: 0, spam: 0, chain: 0};

        start  = 1'b0;
        pready = 1'b0;
        cfg    = '0;
        waits  = '0;
        rst_n  = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        repeat (2) @(negedge clk_apb);
        rst_n = 1'b1;

        prev_chain = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_seq(tp_words, tbl[i].w, prev_chain, tbl[i].chain, tbl[i].spam,
                    1'b1, tbl[i].exp_done, tbl[i].exp_err);
            prev_chain = tbl[i].chain;
        end

        // Reset asserted during the ACCESS of register 2 (cycle 6)
        setup_seq(tp_words, mkw(0, 0, 0, 0, 0));
        @(negedge clk_apb);
        start = 1'b1;
        @(posedge clk_apb);
        @(negedge clk_apb);
        start = 1'b0;
        repeat (5) @(negedge clk_apb);
        chk("ra_paddr", 64'(paddr), 64'd2);
        chk("ra_penable", 64'(penable), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_busy", 64'(busy), 64'd0);
        chk("ra_done", 64'(done), 64'd0);
        chk("ra_err", 64'(err_timeout), 64'd0);
        chk("ra_psel", 64'(psel), 64'd0);
        chk("ra_penable0", 64'(penable), 64'd0);
        chk("ra_pwrite", 64'(pwrite), 64'd0);
        chk("ra_paddr0", 64'(paddr), 64'd0);
        chk("ra_pwdata", 64'(pwdata), 64'd0);
        repeat (2) begin
            @(negedge clk_apb);
            chk("ra_hold_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk_apb);
            chk("ra_idle_busy", 64'(busy), 64'd0);
            chk("ra_idle_psel", 64'(psel), 64'd0);
            chk("ra_idle_done", 64'(done), 64'd0);
        end
        run_seq(tp_words, mkw(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Randomized words and wait profiles against the completion model
        for (int s = 0; s < 10; s++) begin
            rw = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < N + 1; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)       w[i] = 8'($urandom_range(0, 2));
                else if (r < 8)  w[i] = 8'd7;
                else if (r == 8) w[i] = 8'd6;
                else             w[i] = 8'd99;
            end
            run_seq(rw, w, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cfg_loader.md
# apb_cfg_loader

Single-clock APB master that programs the register bank of the APB configuration slave. A one-cycle `start` pulse launches the sequence. The block writes all `NBR_REGS` words from a packed configuration vector, then issues the commit write to address `NBR_REGS`. It then waits for the slave to stretch `pready` until the register bank has been handed to the core domain. It sits between boot/firmware control logic and the APB port of the configuration slave, and it reports completion or a timeout.

## Interface
Parameters:
- `NBR_REGS`, 32: number of 32-bit registers in the slave bank; the commit address equals `NBR_REGS`.
- `TIMEOUT_CYC`, 1024: maximum consecutive ACCESS cycles with `pready` low before abort (≥2).

Ports:
- `clk_apb`  in  1  sole clock; everything is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `cfg_regs_p`  in  32*NBR_REGS  packed register values, word i at bits [32*i+:32]; must stay stable while `busy`.
- `busy`  out  1  high from the first SETUP cycle through the final ACCESS cycle.
- `done`  out  1  one-cycle pulse when the sequence ends, whether it succeeds or times out.
- `err_timeout`  out  1  set together with `done` on timeout; cleared on the next accepted `start`.
- `paddr`  out  $clog2(NBR_REGS)+1  APB address.
- `psel`, `penable`, `pwrite`  out  1 each  APB control.
- `pwdata`  out  32  APB write data.
- `pready`  in  1  APB ready from the slave.

## Operation
- All outputs are registered. Reset value of every output is 0; an asynchronous reset mid-sequence aborts it immediately, with no `done` pulse.
- State machine: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on `start`. This transition loads `idx`=0 and clears `err_timeout`.
  - SETUP -> ACCESS unconditionally.
  - ACCESS, `pready`=1 and `idx`<`NBR_REGS`: `idx`++ and go to SETUP.
  - ACCESS, `pready`=1 and `idx`=`NBR_REGS`: go to IDLE with `done`=1.
  - ACCESS, timeout: go to IDLE with `done`=1 and `err_timeout`=1.
- Internal index `idx` ranges 0..`NBR_REGS` and is `$clog2(NBR_REGS)+1` bits wide; it never wraps.
- Per transfer:
  - `paddr`=`idx`.
  - `pwdata` = `cfg_regs_p[32*idx+:32]` for `idx`<`NBR_REGS`, and 0 for the commit write.
  - `pwrite`=1.
- SETUP drives `psel`=1, `penable`=0. ACCESS drives `psel`=1, `penable`=1.
- In IDLE, `psel`, `penable` and `pwrite` are 0. `paddr` and `pwdata` hold their last values.
- Transfers are write-only; the block never issues reads.
- Timeout counter:
  - Cleared on every SETUP.
  - Increments each ACCESS cycle with `pready`=0.
  - When it reaches `TIMEOUT_CYC`-1 while `pready` is still 0, the transfer aborts and `psel`/`penable` drop the next cycle.
  - If `pready` rises in the same cycle the terminal count is reached, `pready` wins and the transfer completes.
- `start` while `busy` is ignored: no restart and no queuing. `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.

## Timing
- With `start` sampled at edge 0:
  - Register i: SETUP in cycle 1+2i, ACCESS in cycle 2+2i. Back-to-back transfers take 2 cycles each while `pready`=1.
  - Commit: SETUP in cycle 1+2N; ACCESS from cycle 2+2N until `pready`=1 in cycle k.
  - `done` pulses in cycle k+1 and `busy` falls in cycle k+1.
- Minimum sequence length, `start` to `done`: 2N+3 cycles.
- APB outputs stay stable through wait states. `paddr` and `pwdata` change only on the ACCESS->SETUP or IDLE->SETUP transition.
- On timeout (ACCESS entered at cycle a, `pready` never rising), `done` and `err_timeout` go high in cycle a+`TIMEOUT_CYC`.

## Test plan
- `NBR_REGS`=4, `cfg_regs_p` words = 0x11111111, 0x22222222, 0x33333333, 0x44444444; `pready` tied high in ACCESS.
  - Required: addresses 0,1,2,3 carry those words, then a write of 0 to address 4.
  - Required: `done` 11 cycles after `start` and `err_timeout`=0.
- Commit `pready` delayed 7 ACCESS cycles (connected to a real slave with its clock-crossing handshake).
  - Required: `psel`, `penable`, `paddr`=4 and `pwdata`=0 held throughout the wait.
  - Required: `done` exactly one cycle after `pready` rises.
- `TIMEOUT_CYC`=8, `pready` stuck low on the commit.
  - Required: abort after 8 ACCESS cycles, with `done`=1, `err_timeout`=1 and `psel`=0 the next cycle.
  - Required: a subsequent `start` clears `err_timeout`.
- `start` pulsed repeatedly while `busy`.
  - Required: the sequence is unaffected and exactly one `done` is produced.
  - Required: `start` in the `done` cycle launches a new sequence with SETUP in the next cycle.
- `rst_n` asserted during the ACCESS of register 2.
  - Required: all outputs 0 asynchronously and no `done`.
  - Required: after release, the block stays IDLE until `start`, and the next sequence begins at address 0.
- Timeout boundary, `TIMEOUT_CYC`=8: `pready` rises on the 8th ACCESS cycle.
  - Required: the transfer completes normally and `err_timeout`=0.
